// File: rtl/fixed_divider_16bit.sv
// Sequential divider for a 16-bit scaled fixed-point format {scale[2:0], signed[12:0]}.
// The dividend is aligned to the larger scale, then divided with 20 restoring steps.
module fixed_divider_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {IDLE, LOAD, DIV, SIGN, DONE} state_t;

  state_t      state, state_next;
  logic [15:0] a_reg, b_reg;
  logic [4:0]  iter;
  logic [12:0] rem;
  logic [12:0] dvs;
  logic [19:0] quo;
  logic        neg;
  logic [2:0]  scale;

  function automatic logic [12:0] mag13(input logic [12:0] n);
    return n[12] ? (~n + 13'd1) : n;
  endfunction

  // Scale alignment derived from the captured operands.
  logic [2:0] sa, sb, shift, scale_max;
  logic       a_ge;
  always_comb begin
    sa        = a_reg[15:13];
    sb        = b_reg[15:13];
    a_ge      = (sa >= sb);
    shift     = a_ge ? (sa - sb) : (sb - sa);
    scale_max = a_ge ? sa : sb;
  end

  // One restoring step: shift the next dividend bit into the remainder and try to subtract.
  logic [13:0] rem_shift;
  logic        fits;
  logic [19:0] q_signed;
  always_comb begin
    rem_shift = {rem, quo[19]};
    fits      = (rem_shift >= {1'b0, dvs});
    q_signed  = neg ? (~quo + 20'd1) : quo;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (iter == 5'd19) state_next = SIGN;
      SIGN:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // NOTE: operand and working registers are left unreset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter        <= 5'd0;
      out         <= 16'h0000;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= dividend;
          b_reg <= divisor;
        end
        LOAD: begin
          scale <= scale_max;
          quo   <= 20'(mag13(a_reg[12:0])) << shift;
          dvs   <= mag13(b_reg[12:0]);
          neg   <= a_reg[12] ^ b_reg[12];
          rem   <= 13'd0;
          iter  <= 5'd0;
        end
        DIV: begin
          rem  <= fits ? 13'(rem_shift - {1'b0, dvs}) : rem_shift[12:0];
          quo  <= {quo[18:0], fits};
          iter <= iter + 5'd1;
        end
        SIGN: begin
          if (dvs == 13'd0) begin
            out         <= {scale, 13'h0000};
            overflow    <= 1'b1;
            div_by_zero <= 1'b1;
          end else begin
            out         <= {scale, q_signed[12:0]};
            overflow    <= neg ? (quo > 20'd4096) : (quo > 20'd4095);
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_divider_16bit.sv
// Self-checking bench for fixed_divider_16bit: cycle-timeline reference model plus directed literal cases.
module tb_fixed_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'h0;
  logic [15:0] divisor = 16'h0;
  logic [15:0] out;
  logic        busy, done, overflow, div_by_zero;

  always #5 clk = ~clk;

  fixed_divider_16bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .out(out), .busy(busy), .done(done), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] out;
    logic        ov;
    logic        dz;
  } res_t;

  // Expected result from plain integer arithmetic on the format definition.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int sa, sb, sh, sc, na, nb, q;
    sa = int'(a[15:13]);
    sb = int'(b[15:13]);
    na = int'($signed(a[12:0]));
    nb = int'($signed(b[12:0]));
    sh = (sa > sb) ? sa - sb : sb - sa;
    sc = (sa > sb) ? sa : sb;
    if (nb == 0) begin
      r.out = {sc[2:0], 13'h0000};
      r.ov  = 1'b1;
      r.dz  = 1'b1;
    end else begin
      q     = (na * (1 << sh)) / nb;
      r.ov  = (q < -4096) || (q > 4095);
      r.dz  = 1'b0;
      r.out = {sc[2:0], q[12:0]};
    end
    return r;
  endfunction

  // Timeline model: phase counts edges since acceptance; result appears 22 edges in, done for one cycle.
  int          phase = 0;
  res_t        pend;
  logic [15:0] exp_out = 16'h0;
  logic        exp_ov = 1'b0;
  logic        exp_dz = 1'b0;
  logic        check_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase   <= 0;
      exp_out <= 16'h0;
      exp_ov  <= 1'b0;
      exp_dz  <= 1'b0;
    end else if (phase == 0) begin
      if (start) begin
        pend  <= model(dividend, divisor);
        phase <= 1;
      end
    end else if (phase == 22) begin
      phase                    <= 23;
      {exp_out, exp_ov, exp_dz} <= pend;
    end else if (phase == 23) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("busy", busy, phase != 0);
      check("done", done, phase == 23);
      check("out", out, exp_out);
      check("overflow", overflow, exp_ov);
      check("div_by_zero", div_by_zero, exp_dz);
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk);
    #2;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #2;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  // Counts edges until done is sampled high; leaves the caller at the negedge inside the done cycle.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic run_lit(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_out, input logic e_ov, input logic e_dz);
    res_t m;
    m = model(a, b);
    check({name, "_model"}, {m.out, m.ov, m.dz}, {e_out, e_ov, e_dz});
    start_op(a, b);
    wait_done(name, 23);
    check({name, "_out"}, {out, overflow, div_by_zero}, {e_out, e_ov, e_dz});
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d_idx[$];
    res_t m;
    logic [15:0] a, b;

    repeat (3) @(posedge clk);
    #2;
    check_en = 1'b1;
    check("reset_state", {out, busy, done, overflow, div_by_zero}, 20'h0);
    rst_n = 1'b1;

    run_lit("basic",      16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0);
    run_lit("neg_100",    16'h1F9C, 16'h0007, 16'h1FF2, 1'b0, 1'b0);
    run_lit("trunc_m7",   16'h1FF9, 16'h0002, 16'h1FFD, 1'b0, 1'b0);
    run_lit("scale2",     16'h4003, 16'h0002, 16'h4006, 1'b0, 1'b0);
    run_lit("scale7_ovf", 16'hEFFF, 16'h0001, 16'hFF80, 1'b1, 1'b0);
    run_lit("min_by_m1",  16'h1000, 16'h1FFF, 16'h1000, 1'b1, 1'b0);
    run_lit("div_zero",   16'h0064, 16'h2000, 16'h2000, 1'b1, 1'b1);

    // Start pulsed during DIV must not disturb the running division.
    start_op(16'h0064, 16'h0007);
    repeat (6) @(posedge clk);
    #2;
    start = 1'b1; dividend = 16'h1234; divisor = 16'h0001;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done("ignore", 16);
    check("ignore_out", out, 16'h000E);

    // Start held high: one division every 24 cycles, operands changing every cycle.
    @(posedge clk);
    #2;
    start = 1'b1;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) d_idx.push_back(c);
      @(posedge clk);
      #2;
      dividend = 16'($urandom);
      divisor  = 16'($urandom);
    end
    start = 1'b0;
    check("held_done_count", d_idx.size() >= 3, 1'b1);
    if (d_idx.size() >= 3) begin
      check("held_period_1", d_idx[1] - d_idx[0], 24);
      check("held_period_2", d_idx[2] - d_idx[1], 24);
    end
    for (int n = 0; n < 40 && busy; n++) @(posedge clk);
    check("held_drain", busy, 1'b0);

    // Reset during DIV iteration 10, start held through reset and accepted on the first free edge.
    start_op(16'h1F9C, 16'h0007);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b1; dividend = 16'h1FF9; divisor = 16'h0002;
    @(posedge clk);
    #2;
    check("abort_state", {out, busy, done, overflow, div_by_zero}, 20'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    wait_done("post_reset", 23);
    check("post_reset_out", out, 16'h1FFD);

    // Randomized operands, including zero divisors and random idle gaps.
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 8 == 0) b[12:0] = 13'h0;
      if (i % 5 == 1) b[15:13] = a[15:13];
      m = model(a, b);
      start_op(a, b);
      wait_done("rand", 23);
      check("rand_out", {out, overflow, div_by_zero}, {m.out, m.ov, m.dz});
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (30) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
